// File: rtl/adder_tree_pipe_if.sv
`timescale 1ns/1ps
// Streaming handshake bundle for adder_tree_pipe: a lane vector goes in, and the exact sum plus its mode flag come out.
interface adder_tree_pipe_if #(
   parameter int WIDTH = 17,
   parameter int N_IN  = 8
);
   localparam int OW = WIDTH + $clog2(N_IN);

   logic                  in_valid;
   logic                  in_ready;
   logic [N_IN*WIDTH-1:0] in_data;
   logic                  in_signed;
   logic                  out_valid;
   logic                  out_ready;
   logic [OW-1:0]         out_sum;
   logic                  out_signed;

   modport master (
      output in_valid, in_data, in_signed, out_ready,
      input  in_ready, out_valid, out_sum, out_signed
   );

   modport slave (
      input  in_valid, in_data, in_signed, out_ready,
      output in_ready, out_valid, out_sum, out_signed
   );
endinterface

// File: rtl/adder_tree_pipe.sv
`timescale 1ns/1ps
// Pipelined multi-operand adder. It sums N_IN lanes into one exact WIDTH+log2(N_IN)-bit result with
// one register rank per tree level. The whole pipe is stalled by a single advance signal.
module adder_tree_pipe #(
   parameter int WIDTH = 17,
   parameter int N_IN  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   adder_tree_pipe_if.slave bus
);
   localparam int LVL = $clog2(N_IN);
   localparam int OW  = WIDTH + LVL;
   localparam int NN  = N_IN - 1;

   // r_node is a heap of internal tree nodes. Indices [0, N_IN/2) form the first rank, and each
   // following rank sits directly after the one before it, so the final sum lands in r_node[NN-1].
   logic           w_adv;
   logic [OW-1:0]  w_ext  [N_IN];
   logic [OW-1:0]  w_nxt  [NN];
   logic [OW-1:0]  r_node [NN];
   logic [LVL-1:0] r_valid;
   logic [LVL-1:0] r_signed;

   assign w_adv = !r_valid[LVL-1] || bus.out_ready;

   always_comb begin
      // NOTE: every element is assigned on every pass, so always_comb cannot infer a latch here.
      for (int k = 0; k < N_IN; k++) begin
         w_ext[k] = {{LVL{bus.in_signed & bus.in_data[k*WIDTH+WIDTH-1]}},
                     bus.in_data[k*WIDTH +: WIDTH]};
      end
   end

   always_comb begin
      for (int i = 0; i < N_IN/2; i++) begin
         w_nxt[i] = w_ext[2*i] + w_ext[2*i+1];
      end
      for (int i = N_IN/2; i < NN; i++) begin
         w_nxt[i] = r_node[2*i-N_IN] + r_node[2*i-N_IN+1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data ranks are plain flops rather than a RAM. Clearing them makes out_sum read 0 during reset.
         for (int i = 0; i < NN; i++) begin
            r_node[i] <= '0;
         end
         r_valid  <= '0;
         r_signed <= '0;
      end else if (w_adv) begin
         // NOTE: non-blocking updates let every rank read its predecessor's pre-edge value.
         r_node      <= w_nxt;
         r_valid[0]  <= bus.in_valid;
         r_signed[0] <= bus.in_signed;
         for (int j = 1; j < LVL; j++) begin
            r_valid[j]  <= r_valid[j-1];
            r_signed[j] <= r_signed[j-1];
         end
      end
   end

   assign bus.in_ready   = w_adv;
   assign bus.out_valid  = r_valid[LVL-1];
   assign bus.out_signed = r_signed[LVL-1];
   assign bus.out_sum    = r_node[NN-1];
endmodule
